// File: rtl/tt_sweep_ctrl.sv
// Clocked equivalence sweeper: drives {x,y,z} through 0..7, compares s1/s2 after SETTLE cycles.
// Optional TT_SWEEP_LOG_EN adds tt_s1/tt_s2 truth-table capture outputs.
module tt_sweep_ctrl #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       s1,
    input  logic       s2,
    output logic       x,
    output logic       y,
    output logic       z,
    output logic       busy,
    output logic       done,
    output logic       equal,
    output logic [3:0] mis_cnt,
    output logic [2:0] first_bad
`ifdef TT_SWEEP_LOG_EN
    ,
    output logic [7:0] tt_s1,
    output logic [7:0] tt_s2
`endif
);

    typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state, state_n;
    logic [2:0] idx, idx_n;
    logic [3:0] cnt, cnt_n;
    logic       busy_n, done_n, equal_n;
    logic [3:0] mis_n;
    logic [2:0] first_n;
`ifdef TT_SWEEP_LOG_EN
    logic [7:0] tt_s1_n, tt_s2_n;
`endif

    assign {x, y, z} = idx;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        busy_n  = busy;
        done_n  = 1'b0;
        equal_n = equal;
        mis_n   = mis_cnt;
        first_n = first_bad;
`ifdef TT_SWEEP_LOG_EN
        tt_s1_n = tt_s1;
        tt_s2_n = tt_s2;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = APPLY;
                    idx_n   = '0;
                    cnt_n   = '0;
                    mis_n   = '0;
                    first_n = '0;
                    equal_n = 1'b0;
                    busy_n  = 1'b1;
`ifdef TT_SWEEP_LOG_EN
                    tt_s1_n = '0;
                    tt_s2_n = '0;
`endif
                end
            end
            APPLY: begin
                if (cnt == SETTLE_LAST) begin
                    state_n = SAMPLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            SAMPLE: begin
                if (s1 != s2) begin
                    mis_n = mis_cnt + 4'd1;
                    // mis_cnt still zero means this is the first mismatch of the sweep
                    if (mis_cnt == 4'd0)
                        first_n = idx;
                end
`ifdef TT_SWEEP_LOG_EN
                tt_s1_n[idx] = s1;
                tt_s2_n[idx] = s2;
`endif
                if (idx == 3'd7) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                    equal_n = (mis_n == 4'd0);
                end else begin
                    idx_n   = idx + 3'd1;
                    state_n = APPLY;
                end
            end
            DONE: begin
                state_n = IDLE;
                busy_n  = 1'b0;
                idx_n   = '0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            equal     <= 1'b0;
            mis_cnt   <= '0;
            first_bad <= '0;
`ifdef TT_SWEEP_LOG_EN
            tt_s1     <= '0;
            tt_s2     <= '0;
`endif
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            cnt       <= cnt_n;
            busy      <= busy_n;
            done      <= done_n;
            equal     <= equal_n;
            mis_cnt   <= mis_n;
            first_bad <= first_n;
`ifdef TT_SWEEP_LOG_EN
            tt_s1     <= tt_s1_n;
            tt_s2     <= tt_s2_n;
`endif
        end
    end

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Bench for tt_sweep_ctrl: table-driven sweeps with a result scoreboard plus hand-written
// sequences for SETTLE=3 stepping, ignored start, mid-sweep reset and held start.
module tb_tt_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       start3 = 1'b0;
    logic [2:0] mode = 3'd0;

    logic       s1, s2, x, y, z, busy, done, equal;
    logic [3:0] mis_cnt;
    logic [2:0] first_bad;
    logic       s1_3, s2_3, x3, y3, z3, busy3, done3, equal3;
    logic [3:0] mis_cnt3;
    logic [2:0] first_bad3;
`ifdef TT_SWEEP_LOG_EN
    logic [7:0] tt_s1, tt_s2, tt_s1_3, tt_s2_3;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    // Reference expression unit: s1 is the true long form, s2 a selectable (possibly faulty) short form
    function automatic logic long_form(logic a, logic b);
        return a & ~(~a | b);
    endfunction

    function automatic logic short_form(logic [2:0] m, logic a, logic b, logic c);
        case (m)
            3'd0:    return a & ~b;
            3'd1:    return a & b;
            3'd2:    return 1'b1;
            3'd3:    return ~(a & ~b);
            default: return (a & ~b) ^ (a & b & c);
        endcase
    endfunction

    always_comb begin
        s1   = long_form(x, y);
        s2   = short_form(mode, x, y, z);
        s1_3 = long_form(x3, y3);
        s2_3 = short_form(mode, x3, y3, z3);
    end

    tt_sweep_ctrl #(.SETTLE(1)) dut (
        .clk(clk), .rst(rst), .start(start), .s1(s1), .s2(s2),
        .x(x), .y(y), .z(z), .busy(busy), .done(done), .equal(equal),
        .mis_cnt(mis_cnt), .first_bad(first_bad)
`ifdef TT_SWEEP_LOG_EN
        , .tt_s1(tt_s1), .tt_s2(tt_s2)
`endif
    );

    tt_sweep_ctrl #(.SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .s1(s1_3), .s2(s2_3),
        .x(x3), .y(y3), .z(z3), .busy(busy3), .done(done3), .equal(equal3),
        .mis_cnt(mis_cnt3), .first_bad(first_bad3)
`ifdef TT_SWEEP_LOG_EN
        , .tt_s1(tt_s1_3), .tt_s2(tt_s2_3)
`endif
    );

    typedef struct {
        logic [2:0] mode;
        int         mis;
        int         first;
        int         eq;
        logic [7:0] ts2;
    } vec_t;

    vec_t tbl[5];
    vec_t sb[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic score();
        vec_t e;
        if (sb.size() == 0) begin
            check("sb_unexpected_done", 1, 0);
        end else begin
            e = sb.pop_front();
            check("mis_cnt", int'(mis_cnt), e.mis);
            check("first_bad", int'(first_bad), e.first);
            check("equal", int'(equal), e.eq);
`ifdef TT_SWEEP_LOG_EN
            check("tt_s1", int'(tt_s1), 8'h30);
            check("tt_s2", int'(tt_s2), int'(e.ts2));
`endif
        end
    endtask

    task automatic run_sweep(output int lat);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 1;
        check("busy_after_accept", int'(busy), 1);
        while (!done && lat < 200) begin
            @(posedge clk);
            #1 lat++;
        end
        if (!done) check("done_timeout", 0, 1);
        else score();
        @(posedge clk);
        #1;
        check("busy_after_done", int'(busy), 0);
        check("done_one_cycle", int'(done), 0);
        check("xyz_idle", int'({x, y, z}), 0);
    endtask

    initial begin
        int lat;
        int pulses;
        bit pulsed;
        int times[$];

        tbl[0] = '{3'd0, 0, 0, 1, 8'h30};
        tbl[1] = '{3'd1, 4, 4, 0, 8'hC0};
        tbl[2] = '{3'd2, 6, 0, 0, 8'hFF};
        tbl[3] = '{3'd3, 8, 0, 0, 8'hCF};
        tbl[4] = '{3'd4, 1, 7, 0, 8'hB0};

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_equal", int'(equal), 0);
        check("rst_mis_cnt", int'(mis_cnt), 0);
        check("rst_first_bad", int'(first_bad), 0);
        check("rst_xyz", int'({x, y, z}), 0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            mode = tbl[i].mode;
            sb.push_back(tbl[i]);
            run_sweep(lat);
            check("latency_settle1", lat, 17);
        end

        // SETTLE=3: each vector held 3 cycles plus one sample cycle
        mode = 3'd0;
        @(negedge clk) start3 = 1'b1;
        @(posedge clk);
        #1 start3 = 1'b0;
        lat = 1;
        while (!done3 && lat < 200) begin
            if (lat <= 32) check("xyz_step_settle3", int'({x3, y3, z3}), (lat - 1) / 4);
            @(posedge clk);
            #1 lat++;
        end
        check("latency_settle3", lat, 33);
        check("equal_settle3", int'(equal3), 1);
        check("mis_cnt_settle3", int'(mis_cnt3), 0);

        // start pulsed mid-sweep at idx=2 must not disturb the running sweep
        mode = 3'd1;
        sb.push_back(tbl[1]);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 1;
        pulsed = 0;
        while (!done && lat < 200) begin
            if (!pulsed && {x, y, z} == 3'd2) begin
                start = 1'b1;
                pulsed = 1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1 lat++;
        end
        start = 1'b0;
        check("latency_ignored_start", lat, 17);
        if (done) score();
        repeat (3) @(posedge clk);
        #1 check("no_requeue_busy", int'(busy), 0);

        // reset at idx=5 discards the partial sweep
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        while ({x, y, z} != 3'd5 && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
        check("pre_rst_mis_cnt", int'(mis_cnt), 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("midrst_busy", int'(busy), 0);
        check("midrst_xyz", int'({x, y, z}), 0);
        check("midrst_mis_cnt", int'(mis_cnt), 0);
        check("midrst_first_bad", int'(first_bad), 0);
        pulses = 0;
        repeat (25) begin
            @(posedge clk);
            #1 if (done) pulses++;
        end
        check("midrst_no_done", pulses, 0);

        // rst wins over start in the same cycle
        @(negedge clk) begin rst = 1'b1; start = 1'b1; end
        @(posedge clk);
        #1 check("rst_prio_busy", int'(busy), 0);
        rst = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("rst_prio_idle", int'(busy), 0);

        // start held high: back-to-back sweeps 18 cycles apart
        mode = 3'd0;
        sb.push_back(tbl[0]);
        sb.push_back(tbl[0]);
        @(negedge clk) start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1 if (done) begin
                times.push_back(c);
                score();
            end
        end
        start = 1'b0;
        check("held_done_count", times.size(), 2);
        if (times.size() >= 2) begin
            check("held_first_done", times[0], 17);
            check("held_spacing", times[1] - times[0], 18);
        end
        check("sb_drained", sb.size(), 0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
